// File: rtl/mole_sequencer_if.sv
// Signal bundle between the round engine and its surroundings: settings and
// keypad hits flow in, the light vector and round counters flow out.
interface mole_sequencer_if #(
    parameter int NUM_LIGHTS = 9,
    parameter int CNT_W      = 28
);
    logic                  start;
    logic [CNT_W-1:0]      light_between;
    logic [CNT_W-1:0]      light_on;
    logic [5:0]            total_points;
    logic                  deathmatch;
    logic                  hit_valid;
    logic [3:0]            hit_index;
    logic [NUM_LIGHTS-1:0] light_onehot;
    logic [3:0]            active_index;
    logic [5:0]            score;
    logic [5:0]            misses;
    logic [5:0]            flicks;
    logic                  busy;
    logic                  game_over;

    // Settings/keypad side: drives the controls, watches the round.
    modport master (
        output start, light_between, light_on, total_points, deathmatch,
               hit_valid, hit_index,
        input  light_onehot, active_index, score, misses, flicks, busy, game_over
    );

    // Sequencer side.
    modport slave (
        input  start, light_between, light_on, total_points, deathmatch,
               hit_valid, hit_index,
        output light_onehot, active_index, score, misses, flicks, busy, game_over
    );
endinterface

// File: rtl/mole_sequencer.sv
// Whack-a-mole round engine: waits a gap, lights a pseudo-random light for a
// while, scores keypad hits against it and ends the round after the requested
// number of flicks (or on the first miss in deathmatch).
module mole_sequencer #(
    parameter int          NUM_LIGHTS = 9,
    parameter int          CNT_W      = 28,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic              CLOCK_50,
    input logic              reset,
    mole_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_TALLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] NL_4   = 4'(NUM_LIGHTS);
    localparam logic [3:0] LAST_4 = 4'(NUM_LIGHTS - 1);
    localparam logic [NUM_LIGHTS-1:0] ONE_HOT0 = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           lfsr_q;
    logic [NUM_LIGHTS-1:0] light_q, light_d;
    logic [3:0]            idx_q, idx_d;
    logic [5:0]            score_q, score_d;
    logic [5:0]            misses_q, misses_d;
    logic [5:0]            flicks_q, flicks_d;
    logic [5:0]            total_q, total_d;
    logic [5:0]            flicksInc;
    logic [3:0]            rawIdx, pickIdx;
    logic                  hitOk, hitBad;

    function automatic logic [5:0] satInc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding light choice.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Fold the LFSR nibble onto the board and never repeat the previous light.
    always_comb begin
        rawIdx = lfsr_q[3:0];
        if (rawIdx >= NL_4) begin
            rawIdx = rawIdx - NL_4;
        end
        pickIdx = rawIdx;
        if (rawIdx == idx_q) begin
            pickIdx = (rawIdx == LAST_4) ? 4'd0 : rawIdx + 4'd1;
        end
    end

    assign hitOk     = bus.hit_valid && (bus.hit_index == idx_q);
    assign hitBad    = bus.hit_valid && (bus.hit_index != idx_q);
    assign flicksInc = satInc(flicks_q);

    // Round state machine: next state, counter reloads and score bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        light_d  = light_q;
        idx_d    = idx_q;
        score_d  = score_q;
        misses_d = misses_q;
        flicks_d = flicks_q;
        total_d  = total_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                light_d = '0;
                if (bus.start) begin
                    score_d  = '0;
                    misses_d = '0;
                    flicks_d = '0;
                    total_d  = (bus.total_points == 6'd0) ? 6'd1 : bus.total_points;
                    cnt_d    = bus.light_between;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                light_d = '0;
                if (cnt_q == '0) begin
                    cnt_d   = bus.light_on;
                    idx_d   = pickIdx;
                    light_d = ONE_HOT0 << pickIdx;
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ON: begin
                if (hitOk) begin
                    score_d = satInc(score_q);
                    light_d = '0;
                    state_d = S_TALLY;
                end else if (hitBad && bus.deathmatch) begin
                    misses_d = satInc(misses_q);
                    flicks_d = flicksInc;
                    light_d  = '0;
                    state_d  = S_DONE;
                end else if (cnt_q == '0) begin
                    misses_d = satInc(misses_q);
                    light_d  = '0;
                    if (bus.deathmatch) begin
                        flicks_d = flicksInc;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_TALLY;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TALLY: begin
                light_d  = '0;
                flicks_d = flicksInc;
                if (flicksInc == total_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = bus.light_between;
                    state_d = S_WAIT;
                end
            end
            default: begin
                light_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Round state registers; reset abandons any round in progress.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            light_q  <= '0;
            idx_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            flicks_q <= '0;
            total_q  <= 6'd1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            light_q  <= light_d;
            idx_q    <= idx_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            flicks_q <= flicks_d;
            total_q  <= total_d;
        end
    end

    assign bus.light_onehot = light_q;
    assign bus.active_index = idx_q;
    assign bus.score        = score_q;
    assign bus.misses       = misses_q;
    assign bus.flicks       = flicks_q;
    assign bus.busy         = (state_q == S_WAIT) || (state_q == S_ON) || (state_q == S_TALLY);
    assign bus.game_over    = (state_q == S_DONE);
endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer: round timing, scoring, deathmatch,
// reset/start corner cases and light selection against an LFSR model.
module tb_mole_sequencer;
    logic CLOCK_50;
    logic reset;
    int   checks;
    int   failures;

    mole_sequencer_if #(.NUM_LIGHTS(9), .CNT_W(28)) bus();

    mole_sequencer #(.NUM_LIGHTS(9), .CNT_W(28), .LFSR_SEED(16'hACE1)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    // 50 MHz clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    logic [15:0] modelLfsr;
    logic [3:0]  modelCand;
    logic [3:0]  modelPrevIdx;

    function automatic logic [15:0] lfsrModelNext(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] pickModel(input logic [15:0] v, input logic [3:0] prev);
        logic [3:0] r;
        r = v[3:0];
        if (r >= 4'd9) r = r - 4'd9;
        if (r == prev) r = (r == 4'd8) ? 4'd0 : r + 4'd1;
        return r;
    endfunction

    function automatic logic [3:0] idxOf(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 9; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Reference LFSR: remembers the light that would be chosen at each edge.
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            modelLfsr <= 16'hACE1;
            modelCand <= 4'd0;
        end else begin
            modelCand <= pickModel(modelLfsr, modelPrevIdx);
            modelLfsr <= lfsrModelNext(modelLfsr);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Leaves the caller at the first WAIT cycle of the new round.
    task automatic pulseStart;
        @(negedge CLOCK_50);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
    endtask

    task automatic setTiming(input int between, input int on, input int total, input logic dm);
        bus.light_between = 28'(between);
        bus.light_on      = 28'(on);
        bus.total_points  = 6'(total);
        bus.deathmatch    = dm;
    endtask

    task automatic hitLit(input logic correct);
        logic [3:0] i;
        i = idxOf(bus.light_onehot);
        bus.hit_valid = 1'b1;
        bus.hit_index = correct ? i : ((i == 4'd8) ? 4'd0 : i + 4'd1);
        @(negedge CLOCK_50);
        bus.hit_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        waitCycles(2);
        checks++;
        if (bus.light_onehot !== 9'd0 || bus.active_index !== 4'd0 || bus.busy !== 1'b0 || bus.game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual light=%b idx=%0d busy=%b over=%b required 0/0/0/0",
                     bus.light_onehot, bus.active_index, bus.busy, bus.game_over);
        end
        checks++;
        if (bus.score !== 6'd0 || bus.misses !== 6'd0 || bus.flicks !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts actual %0d/%0d/%0d required 0/0/0", bus.score, bus.misses, bus.flicks);
        end
        reset = 1'b0;
        waitCycles(1);
    endtask

    task automatic test_timeout_round;
        setTiming(3, 4, 2, 1'b0);
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.light_onehot !== 9'd0 || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL gap_dark cycle=%0d actual light=%b busy=%b required 0/1", i, bus.light_onehot, bus.busy);
            end
            waitCycles(1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!$onehot(bus.light_onehot)) begin
                failures++;
                $display("[TB] FAIL lit_window cycle=%0d actual light=%b required one bit set", i, bus.light_onehot);
            end
            waitCycles(1);
        end
        checks++;
        if (bus.light_onehot !== 9'd0 || bus.misses !== 6'd1) begin
            failures++;
            $display("[TB] FAIL timeout_tally actual light=%b misses=%0d required 0/1", bus.light_onehot, bus.misses);
        end
        waitCycles(1);
        checks++;
        if (bus.flicks !== 6'd1 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_flick actual flicks=%0d busy=%b required 1/1", bus.flicks, bus.busy);
        end
        waitCycles(10);
        checks++;
        if (bus.game_over !== 1'b1 || bus.misses !== 6'd2 || bus.score !== 6'd0 || bus.flicks !== 6'd2 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_done actual over=%b misses=%0d score=%0d flicks=%0d busy=%b required 1/2/0/2/0",
                     bus.game_over, bus.misses, bus.score, bus.flicks, bus.busy);
        end
    endtask

    task automatic test_hits;
        setTiming(3, 4, 2, 1'b0);
        pulseStart();
        waitCycles(6);
        hitLit(1'b1);
        checks++;
        if (bus.light_onehot !== 9'd0 || bus.score !== 6'd1) begin
            failures++;
            $display("[TB] FAIL hit_mid actual light=%b score=%0d required 0/1", bus.light_onehot, bus.score);
        end
        waitCycles(9);
        checks++;
        if (!$onehot(bus.light_onehot)) begin
            failures++;
            $display("[TB] FAIL last_lit actual light=%b required one bit set", bus.light_onehot);
        end
        hitLit(1'b1);
        checks++;
        if (bus.score !== 6'd2 || bus.misses !== 6'd0) begin
            failures++;
            $display("[TB] FAIL hit_last actual score=%0d misses=%0d required 2/0", bus.score, bus.misses);
        end
        waitCycles(1);
        checks++;
        if (bus.game_over !== 1'b1 || bus.flicks !== 6'd2) begin
            failures++;
            $display("[TB] FAIL hits_done actual over=%b flicks=%0d required 1/2", bus.game_over, bus.flicks);
        end
    endtask

    task automatic test_deathmatch;
        int guard;
        setTiming(3, 4, 2, 1'b1);
        pulseStart();
        waitCycles(4);
        hitLit(1'b0);
        checks++;
        if (bus.game_over !== 1'b1 || bus.misses !== 6'd1 || bus.flicks !== 6'd1 || bus.light_onehot !== 9'd0) begin
            failures++;
            $display("[TB] FAIL dm_wrong actual over=%b misses=%0d flicks=%0d light=%b required 1/1/1/0",
                     bus.game_over, bus.misses, bus.flicks, bus.light_onehot);
        end
        bus.deathmatch = 1'b0;
        pulseStart();
        waitCycles(4);
        hitLit(1'b0);
        checks++;
        if (!$onehot(bus.light_onehot) || bus.misses !== 6'd0) begin
            failures++;
            $display("[TB] FAIL wrong_ignored actual light=%b misses=%0d required lit/0", bus.light_onehot, bus.misses);
        end
        waitCycles(4);
        checks++;
        if (bus.light_onehot !== 9'd0 || bus.misses !== 6'd1 || bus.game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrong_timeout actual light=%b misses=%0d over=%b required 0/1/0",
                     bus.light_onehot, bus.misses, bus.game_over);
        end
        guard = 0;
        while (bus.game_over !== 1'b1 && guard < 100) begin
            waitCycles(1);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("[TB] FAIL dm_round_end actual timeout required game_over");
        end
    endtask

    task automatic test_total_points;
        int guard;
        setTiming(0, 0, 0, 1'b0);
        pulseStart();
        waitCycles(3);
        checks++;
        if (bus.game_over !== 1'b1 || bus.flicks !== 6'd1 || bus.misses !== 6'd1) begin
            failures++;
            $display("[TB] FAIL total_zero actual over=%b flicks=%0d misses=%0d required 1/1/1",
                     bus.game_over, bus.flicks, bus.misses);
        end
        setTiming(0, 3, 63, 1'b0);
        pulseStart();
        guard = 0;
        while (bus.game_over !== 1'b1 && guard < 2000) begin
            bus.hit_valid = (bus.light_onehot != 9'd0);
            bus.hit_index = idxOf(bus.light_onehot);
            waitCycles(1);
            guard++;
        end
        bus.hit_valid = 1'b0;
        checks++;
        if (bus.game_over !== 1'b1 || bus.score !== 6'd63 || bus.flicks !== 6'd63 || bus.misses !== 6'd0) begin
            failures++;
            $display("[TB] FAIL total_63 actual over=%b score=%0d flicks=%0d misses=%0d required 1/63/63/0",
                     bus.game_over, bus.score, bus.flicks, bus.misses);
        end
    endtask

    task automatic test_reset_mid;
        setTiming(3, 4, 2, 1'b0);
        pulseStart();
        waitCycles(4);
        hitLit(1'b1);
        waitCycles(5);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.light_onehot !== 9'd0 || bus.score !== 6'd0 || bus.busy !== 1'b0 || bus.flicks !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid actual light=%b score=%0d busy=%b flicks=%0d required 0/0/0/0",
                     bus.light_onehot, bus.score, bus.busy, bus.flicks);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_start_busy;
        int guard;
        setTiming(3, 4, 2, 1'b0);
        pulseStart();
        waitCycles(1);
        pulseStart();
        waitCycles(1);
        checks++;
        if (!$onehot(bus.light_onehot)) begin
            failures++;
            $display("[TB] FAIL start_busy_lit actual light=%b required one bit set", bus.light_onehot);
        end
        waitCycles(6);
        checks++;
        if (bus.flicks !== 6'd1 || bus.misses !== 6'd1) begin
            failures++;
            $display("[TB] FAIL start_busy_counts actual flicks=%0d misses=%0d required 1/1", bus.flicks, bus.misses);
        end
        guard = 0;
        while (bus.game_over !== 1'b1 && guard < 100) begin
            waitCycles(1);
            guard++;
        end
        checks++;
        if (bus.game_over !== 1'b1 || bus.misses !== 6'd2) begin
            failures++;
            $display("[TB] FAIL start_busy_done actual over=%b misses=%0d required 1/2", bus.game_over, bus.misses);
        end
        pulseStart();
        checks++;
        if (bus.score !== 6'd0 || bus.misses !== 6'd0 || bus.flicks !== 6'd0 || bus.busy !== 1'b1 || bus.game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart_done actual %0d/%0d/%0d busy=%b over=%b required 0/0/0/1/0",
                     bus.score, bus.misses, bus.flicks, bus.busy, bus.game_over);
        end
    endtask

    task automatic test_lfsr_sequence;
        logic [8:0] prevLight;
        logic [3:0] lastObs;
        int         seen;
        int         guard;
        reset = 1'b1;
        modelPrevIdx = 4'd0;
        lastObs = 4'd0;
        setTiming(0, 0, 50, 1'b0);
        waitCycles(1);
        reset = 1'b0;
        seen = 0;
        for (int round = 0; round < 4; round++) begin
            pulseStart();
            prevLight = 9'd0;
            guard = 0;
            while (bus.game_over !== 1'b1 && guard < 400) begin
                if (bus.light_onehot !== 9'd0 && prevLight === 9'd0) begin
                    seen++;
                    checks++;
                    if (bus.active_index > 4'd8) begin
                        failures++;
                        $display("[TB] FAIL idx_range flick=%0d actual %0d required 0..8", seen, bus.active_index);
                    end
                    checks++;
                    if (seen > 1 && bus.active_index === lastObs) begin
                        failures++;
                        $display("[TB] FAIL idx_repeat flick=%0d actual %0d required not %0d", seen, bus.active_index, lastObs);
                    end
                    checks++;
                    if (bus.active_index !== modelCand || bus.light_onehot !== (9'd1 << modelCand)) begin
                        failures++;
                        $display("[TB] FAIL idx_model flick=%0d actual idx=%0d light=%b required idx=%0d",
                                 seen, bus.active_index, bus.light_onehot, modelCand);
                    end
                    modelPrevIdx = modelCand;
                    lastObs = bus.active_index;
                end
                prevLight = bus.light_onehot;
                waitCycles(1);
                guard++;
            end
            checks++;
            if (guard >= 400) begin
                failures++;
                $display("[TB] FAIL lfsr_round round=%0d actual timeout required game_over", round);
            end
        end
        checks++;
        if (seen != 200) begin
            failures++;
            $display("[TB] FAIL flick_count actual %0d required 200", seen);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        modelPrevIdx  = 4'd0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_index = 4'd0;
        setTiming(3, 4, 2, 1'b0);
        test_reset();
        test_timeout_round();
        test_hits();
        test_deathmatch();
        test_total_points();
        test_reset_mid();
        test_start_busy();
        test_lfsr_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mole_sequencer.md
Name: mole_sequencer

Overview:
- Game-round engine between the difficulty/mode settings and the light controller.
- Picks which of the board lights to raise and times the gap before each light and how long it stays lit.
- Scores keypad hits against the lit position and ends the round after the configured number of flicks, or on the first miss in deathmatch.
- Drives the one-hot light vector that the light controller displays; consumes decoded hits from the keypad controller.

Parameters:
- NUM_LIGHTS, 9, number of board lights; width of light_onehot.
- CNT_W, 28, width of the timing counters and timing inputs.
- LFSR_SEED, 16'hACE1, reset value of the internal LFSR; must be nonzero.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; begins a round from IDLE or DONE, ignored otherwise.
- light_between  input  CNT_W  gap length minus 1, in cycles.
- light_on  input  CNT_W  lit duration minus 1, in cycles.
- total_points  input  6  flicks per round.
- deathmatch  input  1  first miss or wrong hit ends the round.
- hit_valid  input  1  one-cycle pulse from keypad decode.
- hit_index  input  4  key position 0..NUM_LIGHTS-1.
- light_onehot  output  NUM_LIGHTS  registered; bit k set = light k lit.
- active_index  output  4  registered index of the current/last light.
- score  output  6  correct hits this round.
- misses  output  6  timeouts plus deathmatch wrong hits.
- flicks  output  6  completed flicks.
- busy  output  1  high in WAIT/ON/TALLY.
- game_over  output  1  high in DONE.

Behaviour:
- Reset: state IDLE, light_onehot=0, active_index=0, score=0, misses=0, flicks=0, busy=0, game_over=0, LFSR=LFSR_SEED, counter=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state except under reset.
- Index select when entering ON:
  - r = lfsr[3:0]; if r >= 9, r = r - 9.
  - If r equals the previous active_index, r = (r + 1) mod 9.
- States:
  - IDLE: outputs hold. On start: clear score, misses and flicks; latch total_points (0 is treated as 1); load counter with light_between; go to WAIT.
  - WAIT: light_onehot=0. Counter decrements each cycle. When counter==0, next cycle enters ON with the chosen index lit and the counter loaded with light_on. WAIT therefore lasts light_between+1 cycles.
  - ON: light lit; counter decrements.
    - hit_valid with hit_index==active_index: score+1, go to TALLY.
    - hit_valid with a wrong index, deathmatch=0: ignored.
    - hit_valid with a wrong index, deathmatch=1: misses+1, go to DONE.
    - counter==0 with no correct hit: misses+1; go to DONE if deathmatch=1, else TALLY.
    - A correct hit on the counter==0 cycle counts as a hit.
  - TALLY (1 cycle): light_onehot=0, flicks+1. If the new flicks equals the latched total, go to DONE; else reload the counter with light_between and go to WAIT.
  - DONE: light_onehot=0, game_over=1. score, misses and flicks hold. start restarts exactly as from IDLE.
- Deathmatch exit to DONE also increments flicks in the same cycle.
- Hits outside ON are ignored.
- light_between and light_on are sampled only when the counter is loaded; mid-phase changes take effect at the next load. deathmatch is sampled live.
- Counters saturate at 63, never wrap.
- Reset mid-round immediately forces IDLE with all outputs cleared; no partial score survives.
- start while busy has no effect.

Test Plan:
- Reset with light_between=3, light_on=4, total=2; pulse start; send no hits -> light dark for 4 cycles, then lit for 5 cycles. Then TALLY with flicks=1 and misses=1, a second flick, then game_over=1 with misses=2, score=0.
- Same timings; hit the correct index on the 3rd lit cycle -> light clears the next cycle and score=1. Hit the correct index on the last lit cycle (counter==0) -> counted as score, not a miss.
- deathmatch=1, wrong hit_index while lit -> next cycle DONE, misses=1, flicks=1, light_onehot=0. Repeat with deathmatch=0 -> wrong hit ignored, light stays lit until timeout.
- total_points=0 -> round ends after exactly 1 flick. total_points=63 with all hits -> score=63, flicks=63, game_over=1.
- Assert reset during ON -> same cycle light_onehot=0, score=0, busy=0. start pulsed while busy -> no restart, counts continue. start in DONE -> counts cleared and a new round begins.
- Run 200 flicks with a bench model of the LFSR -> active_index always in 0..8, never the same index twice in a row, and matches the model index on every flick.
